// File: rtl/time_counter_if.sv
// Purpose: groups the time_counter control inputs and BCD digit/pulse outputs.
// master: the driver of the inputs and reader of the outputs (testbench / system side).
// slave : the time_counter core.
interface time_counter_if;
    logic       slow_clk_i;
    logic       set_en_i;
    logic       inc_min_i;
    logic       inc_hour_i;
    logic [1:0] hour_t_o;
    logic [3:0] hour_u_o;
    logic [2:0] min_t_o;
    logic [3:0] min_u_o;
    logic [2:0] sec_t_o;
    logic [3:0] sec_u_o;
    logic       tick_o;
    logic       day_wrap_o;

    modport master (
        output slow_clk_i, set_en_i, inc_min_i, inc_hour_i,
        input  hour_t_o, hour_u_o, min_t_o, min_u_o, sec_t_o, sec_u_o,
               tick_o, day_wrap_o
    );

    modport slave (
        input  slow_clk_i, set_en_i, inc_min_i, inc_hour_i,
        output hour_t_o, hour_u_o, min_t_o, min_u_o, sec_t_o, sec_u_o,
               tick_o, day_wrap_o
    );
endinterface

// File: rtl/time_counter.sv
// Purpose: 24-hour BCD timekeeping core. Counts seconds on rising edges of the
// divided slow clock in RUN mode; in SET mode holds seconds at 00 and advances
// minutes/hours on debounced pushbutton rising edges.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset
//   bus    - time_counter_if.slave: slow_clk_i, set_en_i, inc_min_i, inc_hour_i in;
//            hour/min/sec BCD digits, tick_o, day_wrap_o out (all registered)
module time_counter #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    time_counter_if.slave bus
);

    localparam int unsigned N_IN = 3;
    localparam int unsigned IDX_SLOW = 0;
    localparam int unsigned IDX_MIN  = 1;
    localparam int unsigned IDX_HOUR = 2;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    logic [N_IN-1:0]                  w_in;
    logic [SYNC_STAGES-1:0][N_IN-1:0] r_sync;
    logic [N_IN-1:0]                  r_hist;
    logic [N_IN-1:0]                  w_edge;

    state_t r_state;
    state_t w_state_next;

    logic [1:0] r_hour_t, w_hour_t;
    logic [3:0] r_hour_u, w_hour_u;
    logic [2:0] r_min_t,  w_min_t;
    logic [3:0] r_min_u,  w_min_u;
    logic [2:0] r_sec_t,  w_sec_t;
    logic [3:0] r_sec_u,  w_sec_u;
    logic       r_tick,   w_tick;
    logic       r_wrap,   w_wrap;

    assign w_in[IDX_SLOW] = bus.slow_clk_i;
    assign w_in[IDX_MIN]  = bus.inc_min_i;
    assign w_in[IDX_HOUR] = bus.inc_hour_i;

    // Synchronizer chains plus history flop; reset high so a level already
    // high at reset release is not seen as a rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '1;
            r_hist <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

    // Mode state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Digit registers and output pulses
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hour_t <= '0;
            r_hour_u <= '0;
            r_min_t  <= '0;
            r_min_u  <= '0;
            r_sec_t  <= '0;
            r_sec_u  <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else begin
            r_hour_t <= w_hour_t;
            r_hour_u <= w_hour_u;
            r_min_t  <= w_min_t;
            r_min_u  <= w_min_u;
            r_sec_t  <= w_sec_t;
            r_sec_u  <= w_sec_u;
            r_tick   <= w_tick;
            r_wrap   <= w_wrap;
        end
    end

    // Next-state and next-digit logic
    always_comb begin
        w_state_next = bus.set_en_i ? ST_SET : ST_RUN;
        w_hour_t     = r_hour_t;
        w_hour_u     = r_hour_u;
        w_min_t      = r_min_t;
        w_min_u      = r_min_u;
        w_sec_t      = r_sec_t;
        w_sec_u      = r_sec_u;
        w_tick       = 1'b0;
        w_wrap       = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_edge[IDX_SLOW]) begin
                    w_tick = 1'b1;
                    if (r_sec_u < 4'd9) begin
                        w_sec_u = r_sec_u + 4'd1;
                    end else begin
                        w_sec_u = 4'd0;
                        if (r_sec_t < 3'd5) begin
                            w_sec_t = r_sec_t + 3'd1;
                        end else begin
                            w_sec_t = 3'd0;
                            if (r_min_u < 4'd9) begin
                                w_min_u = r_min_u + 4'd1;
                            end else begin
                                w_min_u = 4'd0;
                                if (r_min_t < 3'd5) begin
                                    w_min_t = r_min_t + 3'd1;
                                end else begin
                                    w_min_t = 3'd0;
                                    // 23 -> 00 closes the day
                                    if (r_hour_t >= 2'd2 && r_hour_u >= 4'd3) begin
                                        w_hour_t = 2'd0;
                                        w_hour_u = 4'd0;
                                        w_wrap   = 1'b1;
                                    end else if (r_hour_u >= 4'd9) begin
                                        w_hour_u = 4'd0;
                                        w_hour_t = r_hour_t + 2'd1;
                                    end else begin
                                        w_hour_u = r_hour_u + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                end
            end
            ST_SET: begin
                // Seconds pinned to 00; slow edges dropped; buttons never carry.
                w_sec_t = 3'd0;
                w_sec_u = 4'd0;
                if (w_edge[IDX_MIN]) begin
                    if (r_min_u < 4'd9) begin
                        w_min_u = r_min_u + 4'd1;
                    end else begin
                        w_min_u = 4'd0;
                        w_min_t = (r_min_t < 3'd5) ? r_min_t + 3'd1 : 3'd0;
                    end
                end
                if (w_edge[IDX_HOUR]) begin
                    if (r_hour_t >= 2'd2 && r_hour_u >= 4'd3) begin
                        w_hour_t = 2'd0;
                        w_hour_u = 4'd0;
                    end else if (r_hour_u >= 4'd9) begin
                        w_hour_u = 4'd0;
                        w_hour_t = r_hour_t + 2'd1;
                    end else begin
                        w_hour_u = r_hour_u + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    assign bus.hour_t_o   = r_hour_t;
    assign bus.hour_u_o   = r_hour_u;
    assign bus.min_t_o    = r_min_t;
    assign bus.min_u_o    = r_min_u;
    assign bus.sec_t_o    = r_sec_t;
    assign bus.sec_u_o    = r_sec_u;
    assign bus.tick_o     = r_tick;
    assign bus.day_wrap_o = r_wrap;

endmodule

// File: tb/tb_time_counter.sv
// Purpose: scoreboard testbench for time_counter. The reference model keeps
// hours/minutes/seconds as plain integers; each counted second pushes the
// expected BCD word into a queue that a negedge monitor pops on every tick_o.
module tb_time_counter;

    logic clk;
    logic rst;
    time_counter_if bus ();

    time_counter #(.SYNC_STAGES(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n_ticks  = 0;

    int m_h = 0;
    int m_m = 0;
    int m_s = 0;
    bit m_set = 1'b0;

    logic [20:0] exp_q[$];
    bit prev_tick = 1'b0;

    // Expected output word: {day_wrap, hour_t, hour_u, min_t, min_u, sec_t, sec_u}
    function automatic logic [20:0] pack(int h, int m, int s, bit w);
        return {w, 2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10),
                3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [20:0] dut_word();
        return {bus.day_wrap_o, bus.hour_t_o, bus.hour_u_o, bus.min_t_o,
                bus.min_u_o, bus.sec_t_o, bus.sec_u_o};
    endfunction

    // One counted second in the model, returns whether the day wrapped.
    function automatic bit model_second();
        int total;
        total = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        m_h = total / 3600;
        m_m = (total / 60) % 60;
        m_s = total % 60;
        return (total == 0);
    endfunction

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_word(string name, logic [21:0] act, logic [21:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_now(string name);
        check_word(name, {1'b0, dut_word()}, {1'b0, pack(m_h, m_m, m_s, 1'b0)});
    endtask

    task automatic slow_pulse();
        bit w;
        bus.slow_clk_i = 1'b1;
        if (!m_set) begin
            w = model_second();
            exp_q.push_back(pack(m_h, m_m, m_s, w));
        end
        cycles(2);
        bus.slow_clk_i = 1'b0;
        cycles(2);
    endtask

    task automatic btn_pulse(bit mn, bit hr);
        bus.inc_min_i  = mn;
        bus.inc_hour_i = hr;
        if (m_set) begin
            if (mn) m_m = (m_m + 1) % 60;
            if (hr) m_h = (m_h + 1) % 24;
        end
        cycles(2);
        bus.inc_min_i  = 1'b0;
        bus.inc_hour_i = 1'b0;
        cycles(2);
    endtask

    task automatic set_mode(bit s);
        bus.set_en_i = s;
        m_set = s;
        if (s) m_s = 0;
        cycles(3);
    endtask

    // Asynchronous reset asserted between edges; digits must clear at once.
    task automatic do_reset(string name);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_word(name, {bus.tick_o, dut_word()}, 22'd0);
        m_h = 0; m_m = 0; m_s = 0; m_set = 1'b0;
        bus.set_en_i = 1'b0;
        exp_q.delete();
        cycles(2);
        rst = 1'b0;
        cycles(2);
    endtask

    // Monitor: every tick must match the next expected second.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tick_o) begin
                n_ticks++;
                n_assert++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tick: got %h, expected no tick", dut_word());
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    if (dut_word() !== e) begin
                        n_fail++;
                        $display("FAIL tick_value: got %h, expected %h", dut_word(), e);
                    end
                end
                if (prev_tick) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL tick_width: tick high 2 cycles, expected 1");
                end
            end else if (bus.day_wrap_o) begin
                n_assert++;
                n_fail++;
                $display("FAIL wrap_without_tick: day_wrap 1, expected 0");
            end
            prev_tick = bus.tick_o;
        end else begin
            prev_tick = 1'b0;
        end
    end

    initial begin
        #(600000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [20:0] old_w, new_w;
        bit w;

        rst = 1'b1;
        bus.slow_clk_i = 1'b0;
        bus.set_en_i   = 1'b0;
        bus.inc_min_i  = 1'b0;
        bus.inc_hour_i = 1'b0;
        cycles(3);
        check_word("reset_state", {bus.tick_o, dut_word()}, 22'd0);
        rst = 1'b0;
        cycles(3);

        // Reset mid-count, then slow held high across release
        for (int i = 0; i < 37; i++) slow_pulse();
        check_now("count_37");
        bus.slow_clk_i = 1'b1;
        do_reset("async_reset");
        cycles(6);
        check_now("no_edge_after_reset");
        bus.slow_clk_i = 1'b0;
        cycles(3);

        // Latency: rise before edge k, update after edge k+2
        old_w = pack(m_h, m_m, m_s, 1'b0);
        bus.slow_clk_i = 1'b1;
        w = model_second();
        new_w = pack(m_h, m_m, m_s, w);
        exp_q.push_back(new_w);
        @(posedge clk); #1;
        check_word("latency_k", {bus.tick_o, dut_word()}, {1'b0, old_w});
        @(posedge clk); #1;
        check_word("latency_k1", {bus.tick_o, dut_word()}, {1'b0, old_w});
        @(posedge clk); #1;
        check_word("latency_k2", {bus.tick_o, dut_word()}, {1'b1, new_w});
        @(negedge clk);
        bus.slow_clk_i = 1'b0;
        cycles(3);

        // Basic run
        do_reset("reset_before_run");
        t0 = n_ticks;
        for (int i = 0; i < 60; i++) slow_pulse();
        check_now("run_00_01_00");
        check_word("tick_count_60", 22'(n_ticks - t0), 22'd60);
        for (int i = 60; i < 3600; i++) slow_pulse();
        check_now("run_01_00_00");

        // Day wrap
        do_reset("reset_before_wrap");
        set_mode(1'b1);
        for (int i = 0; i < 23; i++) btn_pulse(1'b0, 1'b1);
        for (int i = 0; i < 59; i++) btn_pulse(1'b1, 1'b0);
        check_now("set_23_59");
        set_mode(1'b0);
        for (int i = 0; i < 59; i++) slow_pulse();
        check_now("run_23_59_59");
        slow_pulse();
        check_now("wrap_00_00_00");

        // SET mode rules from 12:34:56
        do_reset("reset_before_set");
        set_mode(1'b1);
        for (int i = 0; i < 12; i++) btn_pulse(1'b0, 1'b1);
        for (int i = 0; i < 34; i++) btn_pulse(1'b1, 1'b0);
        set_mode(1'b0);
        for (int i = 0; i < 56; i++) slow_pulse();
        check_now("at_12_34_56");
        set_mode(1'b1);
        check_now("set_clears_sec");
        for (int i = 0; i < 3; i++) slow_pulse();
        check_now("set_ignores_slow");
        for (int i = 0; i < 25; i++) btn_pulse(1'b1, 1'b0);
        check_now("set_12_59");
        btn_pulse(1'b1, 1'b0);
        check_now("min_wrap_no_carry");
        btn_pulse(1'b1, 1'b1);
        check_now("both_buttons_13_01");
        for (int i = 0; i < 11; i++) btn_pulse(1'b0, 1'b1);
        check_now("hour_wrap_00");

        // RUN ignores buttons
        set_mode(1'b0);
        for (int i = 0; i < 5; i++) btn_pulse(1'b1, 1'b1);
        check_now("run_ignores_buttons");
        slow_pulse();
        check_now("run_resumes_from_00");

        // Random mix of slow edges and buttons in RUN and SET
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) set_mode(~m_set);
            else if (r < 6) slow_pulse();
            else btn_pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_now("random_final");

        cycles(4);
        check_word("queue_drained", 22'(exp_q.size()), 22'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
